dcpu_alu_seq: RTL
=================

# dcpu_alu_seq

ALU sequencer for the DCPU-16 core. It accepts decoded basic instructions from the decode stage over a valid/ready handshake and drives the `dcpu_alu` operand and opcode inputs from registered copies. It models the DCPU-16 per-opcode cycle cost, captures the result, and updates the architectural O (overflow) register. It also evaluates IF* conditions and returns result, write-enable and skip to writeback over a second valid/ready handshake.

## Interface
- `DW`, default 16: data width; must equal the ALU width.
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  1: decode presents an instruction.
- `req_ready`  out  1: sequencer can accept.
- `req_opcode`  in  4: basic opcode, encoded per `dcpu_defines.v` (`OP_SET`..`OP_IFB`; 0 is non-basic).
- `req_a`, `req_b`  in  DW: operand values.
- `alu_opcode`  out  4: registered opcode driven to the ALU.
- `alu_a`, `alu_b`  out  DW: registered operands driven to the ALU.
- `alu_result`, `alu_overflow`  in  DW: combinational ALU outputs.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: writeback accepts.
- `rsp_result`  out  DW: captured result.
- `rsp_wr`  out  1: write `rsp_result` to operand a's destination.
- `rsp_skip`  out  1: skip the next instruction (failed IF*).
- `rsp_err`  out  1: non-basic opcode was presented.
- `o_reg`  out  DW: architectural O register.

## Operation
- **States:** IDLE, EXEC, DONE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`: latch opcode and operands into `alu_*`, load the cost counter, go to EXEC.
- **EXEC:**
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1: capture the response fields, conditionally update `o_reg`, go to DONE.
- **DONE:**
  - `rsp_valid`=1 and all `rsp_*` are held stable.
  - On `rsp_ready`: go to IDLE.
- **Cycle cost:**
  - SET, AND, BOR, XOR: 1.
  - ADD, SUB, MUL, SHL, SHR: 2.
  - DIV, MOD: 3.
  - IFE, IFN, IFG, IFB: 2, plus 1 when the condition fails.
  - Opcode 0: 1.
- **IF* conditions** are evaluated locally from the latched operands; IFG is unsigned.
  - IFE: a==b. IFN: a!=b. IFG: a>b. IFB: (a&b)!=0.
  - Response: `rsp_skip`=~cond, `rsp_wr`=0, `rsp_result`=0.
- **Arithmetic ops:**
  - `rsp_result`=`alu_result`, `rsp_wr`=1.
  - For ADD, SUB, MUL, DIV, SHL, SHR: `o_reg` ← `alu_overflow` at the capture edge.
  - SET, MOD, AND, BOR, XOR leave `o_reg` unchanged.
- **Opcode 0:** `rsp_err`=1, `rsp_wr`=0, `rsp_skip`=0, `o_reg` unchanged.
- `o_reg` is never written outside the capture edge.

## Timing
- **Reset:** while `rst` is high, state→IDLE and every output is 0, including `req_ready`, `rsp_valid` and `o_reg`.
- **First cycle after reset:** `req_ready`=1.
- **Reset mid-operation:** any EXEC or DONE contents are discarded with no response, and `o_reg` is cleared.
- **Latency:** accept at edge k → `rsp_valid` high after edge k+N, where N is the cycle cost.
- **Throughput:** `req_ready` is high only in IDLE. The minimum issue interval is N+2 cycles when `rsp_ready` is held high.
- **Backpressure:** `rsp_valid` stays high until `rsp_ready`, with all outputs stable. No new request is accepted meanwhile.
- **Simultaneous `rsp_ready` and `req_valid` in DONE:** the response completes; the request waits for the IDLE cycle.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- **`DCPU_CYCLE_ACCURATE_EN` defined:** cost table as above.
- **Not defined:** every opcode costs N=1, including a failed IF*. Function, `o_reg` and skip behaviour are identical.

## Structure
- **Additions to `dcpu_defines.v`:**
  - cost constants `CYC_SIMPLE`=1, `CYC_ARITH`=2, `CYC_DIVMOD`=3, `CYC_IF`=2, `CYC_IF_FAIL`=1;
  - state encodings `SEQ_IDLE`, `SEQ_EXEC`, `SEQ_DONE`.
- **Sub-module `dcpu_alu_cost`:** combinational map from opcode plus IF-fail to a 2-bit cycle count. It holds the `DCPU_CYCLE_ACCURATE_EN` switch.
- `dcpu_alu` is instantiated alongside the sequencer at core level, not inside it.

## Test plan
- ADD a=3, b=5 → `rsp_result`=8, `rsp_wr`=1, `o_reg`=0, `rsp_valid` 2 cycles after accept.
- ADD a=FFFF, b=FFFF → `rsp_result`=FFFE, `o_reg`=0001. Follow with SET a=1 → `o_reg` stays 0001, latency 1.
- SUB a=3, b=5 → `rsp_result`=FFFE, `o_reg`=FFFF.
- DIV a=7, b=2 → result 3, latency 3.
- IFE 5,5 → `rsp_skip`=0, latency 2. IFE 5,6 → `rsp_skip`=1, latency 3; with the macro undefined, both have latency 1.
- **Backpressure, error and reset:**
  - Hold `rsp_ready`=0 for 4 cycles after `rsp_valid` → outputs stable and `req_ready`=0.
  - Opcode 0 → `rsp_err`=1, `rsp_wr`=0.
  - `rst` pulsed during the EXEC of a DIV → no response, `o_reg`=0, `req_ready`=1 on the next cycle.

Source files
------------

// File: rtl/dcpu_alu_seq_pkg.sv
// Shared opcode encodings, cycle-cost constants and sequencer states for the DCPU-16 ALU sequencer.
package dcpu_alu_seq_pkg;

  localparam logic [3:0] OP_NBI = 4'h0;
  localparam logic [3:0] OP_SET = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_MOD = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_BOR = 4'hA;
  localparam logic [3:0] OP_XOR = 4'hB;
  localparam logic [3:0] OP_IFE = 4'hC;
  localparam logic [3:0] OP_IFN = 4'hD;
  localparam logic [3:0] OP_IFG = 4'hE;
  localparam logic [3:0] OP_IFB = 4'hF;

  localparam logic [1:0] CYC_SIMPLE  = 2'd1;
  localparam logic [1:0] CYC_ARITH   = 2'd2;
  localparam logic [1:0] CYC_DIVMOD  = 2'd3;
  localparam logic [1:0] CYC_IF      = 2'd2;
  localparam logic [1:0] CYC_IF_FAIL = 2'd1;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EXEC = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  function automatic logic is_if(input logic [3:0] op);
    return (op == OP_IFE) || (op == OP_IFN) || (op == OP_IFG) || (op == OP_IFB);
  endfunction

  // Opcodes whose ALU overflow output becomes the new architectural O.
  function automatic logic sets_o(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/dcpu_alu_cost.sv
// Opcode -> cycle cost. DCPU_CYCLE_ACCURATE_EN selects the DCPU-16 cost table;
// otherwise every instruction costs a single cycle.
module dcpu_alu_cost
  import dcpu_alu_seq_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_if_fail,
  output logic [1:0] o_cyc
);

  logic [1:0] w_acc;

  always_comb begin
    w_acc = CYC_SIMPLE;
    case (i_opcode)
      OP_NBI, OP_SET, OP_AND, OP_BOR, OP_XOR:     w_acc = CYC_SIMPLE;
      OP_ADD, OP_SUB, OP_MUL, OP_SHL, OP_SHR:     w_acc = CYC_ARITH;
      OP_DIV, OP_MOD:                             w_acc = CYC_DIVMOD;
      OP_IFE, OP_IFN, OP_IFG, OP_IFB:
        w_acc = CYC_IF + (i_if_fail ? CYC_IF_FAIL : 2'd0);
      default:                                    w_acc = CYC_SIMPLE;
    endcase
  end

`ifdef DCPU_CYCLE_ACCURATE_EN
  assign o_cyc = w_acc;
`else
  logic w_unused_acc;
  assign w_unused_acc = ^w_acc;
  assign o_cyc        = CYC_SIMPLE;
`endif

endmodule

// File: rtl/dcpu_alu_seq.sv
// DCPU-16 ALU sequencer: registers operands for an external dcpu_alu, models per-opcode
// cycle cost (see DCPU_CYCLE_ACCURATE_EN in dcpu_alu_cost), evaluates IF* and owns the O register.
module dcpu_alu_seq
  import dcpu_alu_seq_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_opcode,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] alu_overflow,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_wr,
  output logic          rsp_skip,
  output logic          rsp_err,
  output logic [DW-1:0] o_reg
);

  seq_state_t    r_state, w_next;
  logic [1:0]    r_cnt;
  logic [3:0]    r_op;
  logic [DW-1:0] r_a, r_b, r_res, r_o;
  logic          r_wr, r_skip, r_err;
  logic          w_req_ready, w_rsp_valid, w_accept, w_capture;
  logic          w_req_fail, w_cond;
  logic [1:0]    w_cyc;

  // Non-IF opcodes report "true" so they never request a skip.
  function automatic logic f_cond(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      OP_IFE:  return a == b;
      OP_IFN:  return a != b;
      OP_IFG:  return a > b;
      OP_IFB:  return |(a & b);
      default: return 1'b1;
    endcase
  endfunction

  // Cost is fixed at accept time, so the IF outcome is taken from the incoming operands.
  assign w_req_fail = is_if(req_opcode) & ~f_cond(req_opcode, req_a, req_b);

  dcpu_alu_cost u_cost (
    .i_opcode  (req_opcode),
    .i_if_fail (w_req_fail),
    .o_cyc     (w_cyc)
  );

  assign w_cond    = f_cond(r_op, r_a, r_b);
  assign w_accept  = (r_state == SEQ_IDLE) & req_valid;
  assign w_capture = (r_state == SEQ_EXEC) & (r_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEQ_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) w_next = SEQ_EXEC;
      end
      SEQ_EXEC: if (r_cnt == 2'd1) w_next = SEQ_DONE;
      SEQ_DONE: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) w_next = SEQ_IDLE;
      end
      default: w_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_wr   <= 1'b0;
      r_skip <= 1'b0;
      r_err  <= 1'b0;
      r_o    <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= req_opcode;
        r_a   <= req_a;
        r_b   <= req_b;
        r_cnt <= w_cyc;
      end else if ((r_state == SEQ_EXEC) && (r_cnt != 2'd1)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_capture) begin
        r_err  <= (r_op == OP_NBI);
        r_skip <= is_if(r_op) & ~w_cond;
        if (is_if(r_op) || (r_op == OP_NBI)) begin
          r_res <= '0;
          r_wr  <= 1'b0;
        end else begin
          r_res <= alu_result;
          r_wr  <= 1'b1;
        end
        if (sets_o(r_op)) r_o <= alu_overflow;
      end
    end
  end

  // Handshake outputs are forced low for the whole reset assertion, not just after the edge.
  assign req_ready  = w_req_ready & ~rst;
  assign rsp_valid  = w_rsp_valid & ~rst;
  assign alu_opcode = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_result = r_res;
  assign rsp_wr     = r_wr;
  assign rsp_skip   = r_skip;
  assign rsp_err    = r_err;
  assign o_reg      = r_o;

endmodule
